// File: rtl/micro_sequencer.sv
// Horizontal microcode sequencer: fetches a microinstruction from the control-store
// ROM, presents it to the datapath and computes the next control-store address.
module micro_sequencer #(
  parameter int MIR_BUS_WIDTH       = 41,
  parameter int Direction_BUS_WIDTH = 11
) (
  input  logic                           MICROSEQ_CLOCK_50,
  input  logic                           MICROSEQ_RESET_InLow,
  input  logic [MIR_BUS_WIDTH-1:0]       MICROSEQ_Microinstruccion_IN,
  input  logic [3:0]                     MICROSEQ_Flags_IN,
  input  logic [31:0]                    MICROSEQ_IR_IN,
  input  logic                           MICROSEQ_MemAck_IN,
  output logic [Direction_BUS_WIDTH-1:0] MICROSEQ_Direccion_OUT,
  output logic [MIR_BUS_WIDTH-1:0]       MICROSEQ_MIR_OUT,
  output logic                           MICROSEQ_MIRValid_OUT,
  output logic                           MICROSEQ_Stall_OUT
);

  // state   | meaning
  // S_FETCH | latch ROM word at CS_ADDR into MIR (one cycle)
  // S_EXEC  | MIR valid; advance CS_ADDR unless a memory op is still pending
  // S_WAIT  | memory op pending; MIR and CS_ADDR frozen until MemAck
  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_WAIT  = 2'b10
  } state_t;

  localparam logic [Direction_BUS_WIDTH-1:0] ADDR_ONE = 1;

  state_t                         state, state_nxt;
  logic [Direction_BUS_WIDTH-1:0] cs_addr, next_addr, inc_addr, jaddr;
  logic [MIR_BUS_WIDTH-1:0]       mir;
  logic [2:0]                     cond;
  logic                           mem_op, taken, advance, load_mir;

  assign cond     = mir[13:11];
  assign jaddr    = mir[10:0];
  assign mem_op   = mir[19] | mir[18];
  assign inc_addr = cs_addr + ADDR_ONE;

  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b001:  taken = MICROSEQ_Flags_IN[3];
      3'b010:  taken = MICROSEQ_Flags_IN[2];
      3'b011:  taken = MICROSEQ_Flags_IN[1];
      3'b100:  taken = MICROSEQ_Flags_IN[0];
      3'b101:  taken = MICROSEQ_IR_IN[13];
      3'b110:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    next_addr = taken ? jaddr : inc_addr;
    // Decode dispatch: opcode fields select a 4-word slot in the upper half of the store.
    if (cond == 3'b111)
      next_addr = {1'b1, MICROSEQ_IR_IN[31:30], MICROSEQ_IR_IN[24:19], 2'b00};
  end

  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    load_mir  = 1'b0;
    case (state)
      S_FETCH: begin
        load_mir  = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (!mem_op || MICROSEQ_MemAck_IN) begin
          advance   = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (MICROSEQ_MemAck_IN) begin
          advance   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge MICROSEQ_CLOCK_50) begin
    if (!MICROSEQ_RESET_InLow) begin
      state   <= S_FETCH;
      cs_addr <= '0;
      mir     <= '0;
    end else begin
      state <= state_nxt;
      if (load_mir) mir <= MICROSEQ_Microinstruccion_IN;
      if (advance)  cs_addr <= next_addr;
    end
  end

  assign MICROSEQ_Direccion_OUT = cs_addr;
  assign MICROSEQ_MIR_OUT       = mir;
  assign MICROSEQ_MIRValid_OUT  = (state == S_EXEC) || (state == S_WAIT);
  assign MICROSEQ_Stall_OUT     = (state == S_WAIT);

  // Datapath-only fields of MIR and IR bits the sequencer never looks at.
  logic unused_bits;
  assign unused_bits = ^{mir[40:20], mir[17:14], MICROSEQ_IR_IN[29:25],
                         MICROSEQ_IR_IN[18:14], MICROSEQ_IR_IN[12:0]};

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: a behavioural ROM and memory responder drive
// the DUT; each EXEC cycle is matched against a queue of hand-computed expectations.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [40:0] mi;
  logic [3:0]  flags;
  logic [31:0] ir;
  logic        ack;
  logic [10:0] addr;
  logic [40:0] mir;
  logic        valid, stall;

  logic [40:0] rom [0:2047];
  int          lat [0:2047];
  logic        ack_model = 1'b0;
  logic        ack_idle  = 1'b0;
  logic        force_ack = 1'b0;
  int          wcnt = 0;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [10:0] addr;
    logic [40:0] mir;
    int          gap;
    int          stalls;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign mi  = rom[addr];
  assign ack = ack_model | force_ack;

  micro_sequencer dut (
    .MICROSEQ_CLOCK_50            (clk),
    .MICROSEQ_RESET_InLow         (rst_n),
    .MICROSEQ_Microinstruccion_IN (mi),
    .MICROSEQ_Flags_IN            (flags),
    .MICROSEQ_IR_IN               (ir),
    .MICROSEQ_MemAck_IN           (ack),
    .MICROSEQ_Direccion_OUT       (addr),
    .MICROSEQ_MIR_OUT             (mir),
    .MICROSEQ_MIRValid_OUT        (valid),
    .MICROSEQ_Stall_OUT           (stall)
  );

  function automatic logic [40:0] mk(input logic [5:0] tag, input logic rd, input logic wr,
                                     input logic [2:0] cond, input logic [10:0] j);
    return {tag, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, rd, wr, 4'd0, cond, j};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic refill();
    for (int a = 0; a < 2048; a++) begin
      logic [10:0] av;
      av     = a[10:0];
      rom[a] = mk(av[5:0], 1'b0, 1'b0, 3'b000, av ^ 11'h3A5);
      lat[a] = 0;
    end
  endtask

  task automatic push(input logic [10:0] a, input int gap, input int stalls);
    exp_t e;
    e.addr = a; e.mir = rom[a]; e.gap = gap; e.stalls = stalls;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check) begin
      chk("reset_addr",  64'(addr),  64'h0);
      chk("reset_mir",   64'(mir),   64'h0);
      chk("reset_valid", 64'(valid), 64'h0);
      chk("reset_stall", 64'(stall), 64'h0);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL %s_timeout: %0d expected EXEC cycles never seen", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Memory responder: ack after lat[addr] cycles of a pending RD/WR, else ack_idle.
  always @(negedge clk) begin
    if (valid && (mir[19] | mir[18])) begin
      ack_model = (wcnt >= lat[addr]);
      wcnt++;
    end else begin
      ack_model = ack_idle;
      wcnt      = 0;
    end
  end

  // Monitor: one scoreboard entry per EXEC cycle; WAIT cycles must freeze MIR/CS_ADDR.
  int   cyc = 0, last_cyc = 0, stall_cnt = 0;
  bit   have_last = 0;
  exp_t last_e;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      have_last = 0;
      stall_cnt = 0;
    end else if (valid && !stall) begin
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("exec_addr", 64'(addr), 64'(e.addr));
        chk("exec_mir",  64'(mir),  64'(e.mir));
        if (e.gap != 0) begin
          chk("exec_gap",    64'(cyc - last_cyc), 64'(e.gap));
          chk("stall_count", 64'(stall_cnt),      64'(e.stalls));
        end
        last_e    = e;
        have_last = 1;
      end
      last_cyc  = cyc;
      stall_cnt = 0;
    end else if (stall) begin
      stall_cnt++;
      chk("wait_valid", 64'(valid), 64'h1);
      if (have_last) begin
        chk("wait_addr_hold", 64'(addr), 64'(last_e.addr));
        chk("wait_mir_hold",  64'(mir),  64'(last_e.mir));
      end
    end
  end

  initial begin
    rst_n = 1'b0; flags = 4'h0; ir = 32'h0;
    refill();

    // Sequential stepping and 2047 -> 0 wrap.
    rom[2] = mk(6'h21, 1'b0, 1'b0, 3'b110, 11'h7FE);
    do_reset(1'b1);
    push(11'h000, 0, 0); push(11'h001, 2, 0); push(11'h002, 2, 0);
    push(11'h7FE, 2, 0); push(11'h7FF, 2, 0); push(11'h000, 2, 0);
    rst_n = 1'b1;
    drain("seq");

    // Branches taken on z, not taken on n/v/c/IR13, then decode dispatch.
    refill();
    flags = 4'b0100; ir = 32'h81F8_0000;
    rom[11'h000] = mk(6'h31, 1'b0, 1'b0, 3'b010, 11'h155);
    rom[11'h155] = mk(6'h32, 1'b0, 1'b0, 3'b001, 11'h300);
    rom[11'h156] = mk(6'h33, 1'b0, 1'b0, 3'b011, 11'h300);
    rom[11'h157] = mk(6'h34, 1'b0, 1'b0, 3'b100, 11'h300);
    rom[11'h158] = mk(6'h35, 1'b0, 1'b0, 3'b101, 11'h300);
    rom[11'h159] = mk(6'h36, 1'b0, 1'b0, 3'b111, 11'h123);
    do_reset(1'b1);
    push(11'h000, 0, 0); push(11'h155, 2, 0); push(11'h156, 2, 0); push(11'h157, 2, 0);
    push(11'h158, 2, 0); push(11'h159, 2, 0); push(11'h6FC, 2, 0); push(11'h6FD, 2, 0);
    rst_n = 1'b1;
    drain("branch_a");

    // Complementary flags: z not taken; n, v, c, IR13 taken; decode to 0x500.
    refill();
    flags = 4'b1011; ir = 32'h4000_2000;
    rom[11'h000] = mk(6'h11, 1'b0, 1'b0, 3'b010, 11'h155);
    rom[11'h001] = mk(6'h12, 1'b0, 1'b0, 3'b001, 11'h200);
    rom[11'h200] = mk(6'h13, 1'b0, 1'b0, 3'b011, 11'h210);
    rom[11'h210] = mk(6'h14, 1'b0, 1'b0, 3'b100, 11'h220);
    rom[11'h220] = mk(6'h15, 1'b0, 1'b0, 3'b101, 11'h230);
    rom[11'h230] = mk(6'h16, 1'b0, 1'b0, 3'b111, 11'h7FF);
    do_reset(1'b0);
    push(11'h000, 0, 0); push(11'h001, 2, 0); push(11'h200, 2, 0); push(11'h210, 2, 0);
    push(11'h220, 2, 0); push(11'h230, 2, 0); push(11'h500, 2, 0);
    rst_n = 1'b1;
    drain("branch_b");

    // Memory handshakes; ack held high outside memory ops must be ignored.
    refill();
    flags = 4'b0000; ir = 32'h0; ack_idle = 1'b1;
    rom[11'h000] = mk(6'h01, 1'b1, 1'b0, 3'b000, 11'h000); lat[11'h000] = 3;
    rom[11'h001] = mk(6'h02, 1'b0, 1'b1, 3'b110, 11'h040); lat[11'h001] = 0;
    rom[11'h040] = mk(6'h03, 1'b1, 1'b0, 3'b000, 11'h000); lat[11'h040] = 1;
    rom[11'h042] = mk(6'h04, 1'b1, 1'b0, 3'b000, 11'h000); lat[11'h042] = 50;
    do_reset(1'b0);
    push(11'h000, 0, 0); push(11'h001, 5, 3); push(11'h040, 2, 0);
    push(11'h041, 3, 1); push(11'h042, 2, 0);
    rst_n = 1'b1;
    drain("mem");

    // Reset while stalled with MemAck high must win.
    begin
      int n = 0;
      while (!stall && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("wait_entered", 64'(stall), 64'h1);
    end
    @(negedge clk);
    force_ack = 1'b1;
    rst_n     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wait_addr",  64'(addr),  64'h0);
    chk("rst_wait_mir",   64'(mir),   64'h0);
    chk("rst_wait_stall", 64'(stall), 64'h0);
    chk("rst_wait_valid", 64'(valid), 64'h0);
    force_ack = 1'b0;
    push(11'h000, 0, 0);
    rst_n = 1'b1;
    drain("post_reset");

    do_reset(1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
